tt_xor_extractor: RTL and testbench
===================================

Name: tt_xor_extractor

Overview:
Parametrised successor to the fixed 13-stage XOR whitening chain. It holds one shift window of DEPTH bits per channel and produces the parity of selected taps from that window. Tap selection is set at runtime by a mask. The shift is gated by an input-valid strobe, a fill tracker suppresses output until the window is full, and an optional block mode emits one bit per non-overlapping window (decimation). It sits between raw entropy/bit-stream sources and downstream consumers in the TT design.

Parameters:
DEPTH, 13, number of window stages per channel; legal range 2..32.
CHANNELS, 1, number of independent bit streams processed in parallel with the same mask and mode.

Ports:
clk  input  1  system clock; all state updates on its rising edge.
rst_n  input  1  synchronous, active-high reset. Sampled on the rising edge of clk; when 1, all state clears. The suffix does not imply low polarity.
in_valid  input  1  when 1, num is accepted this cycle and the window shifts.
num  input  CHANNELS  one new bit per channel.
tap_mask  input  DEPTH  bit i selects window position i (0 = newest accepted bit, DEPTH-1 = oldest).
mode  input  1  0 = sliding (one output per accepted bit once full), 1 = block (one output per DEPTH accepted bits).
out_valid  output  1  one-cycle pulse; out_bit is valid when this is 1.
out_bit  output  CHANNELS  per-channel parity of (window AND tap_mask).
primed  output  1  1 once DEPTH bits have been accepted since reset or since the last mode change.

Behaviour:
- Window, per channel: w[DEPTH-1:0]. On an accepted cycle (in_valid=1, rst_n=0, no mode change that cycle), w <= {w[DEPTH-2:0], num[c]}.
- When in_valid=0, w and all counters hold; out_valid=0.
- Reset (rst_n=1 at an edge): w=0, fill=0, blk=0, mode_q=mode, out_valid=0, out_bit=0, primed=0. in_valid is ignored during reset. Reset mid-stream discards any partial window.
- fill counter: counts accepted bits and saturates at DEPTH. It needs ceil(log2(DEPTH+1)) bits. primed = (fill==DEPTH), registered.
- Mode change: mode_q holds the registered mode. If mode != mode_q at an edge:
  - mode_q updates.
  - fill and blk clear to 0; primed drops to 0.
  - out_valid is 0.
  - w holds, and that cycle's input is dropped even if in_valid=1.
- Define nw as the next window, {w[DEPTH-2:0], num[c]}.
- Sliding mode (mode_q=0), on an accepted cycle:
  - out_bit[c] <= XOR-reduce(nw & tap_mask).
  - out_valid <= (fill >= DEPTH-1).
  - Latency: result registered at the same edge that accepts the bit, so it is visible the cycle after in_valid.
- Block mode (mode_q=0 → 1 handled via mode change above; blk counts 0..DEPTH-1), on an accepted cycle:
  - blk increments.
  - When blk==DEPTH-1: blk wraps to 0, out_bit[c] <= XOR-reduce(nw & tap_mask), and out_valid <= 1.
  - Otherwise out_valid <= 0.
  - Windows do not overlap. The first output follows exactly DEPTH accepted bits after a clear.
- tap_mask is sampled combinationally on the accepting edge. If tap_mask=0, out_bit=0 while out_valid still pulses normally.
- out_bit holds its last value when out_valid=0.
- With tap_mask all-ones, DEPTH=13, mode=0 and in_valid tied to 1, out_bit after priming equals the XOR of the last 13 inputs.
- Channels share in_valid, fill, blk and mode; only w and out_bit are per-channel.

Test Plan:
1. DEPTH=4, mask=4'b1111, mode=0, reset, then feed valid bits 1,0,1,1 → out_valid=0 for the first 3 bits; out_valid=1 with out_bit=1 the cycle after the 4th bit; primed=1. Next bit 0 → window {0,1,1,0}, out_bit=0, out_valid=1.
2. DEPTH=4, mask=4'b0001, mode=0, primed, feed 1,0,0,1 → out_bit follows each input one cycle later: 1,0,0,1. Then mask=4'b1000 → out_bit equals the bit accepted 3 samples earlier.
3. DEPTH=4, mask=4'b1111, mode=1, feed 8 valid bits 1,1,0,0,1,0,0,0 → exactly two out_valid pulses, after bit 4 (out_bit=0) and after bit 8 (out_bit=1); no other pulses.
4. Stall: during scenario 1, drop in_valid for 5 cycles between bits 2 and 3 → identical out_bit sequence; out_valid stays 0 throughout the gap.
5. Reset and mode change mid-operation:
   - Accept 2 bits, assert rst_n=1 for one cycle → primed=0, out_bit=0; 4 fresh bits are needed before the next out_valid.
   - Separately, toggle mode while primed with in_valid=1 → that bit is dropped, primed=0, and the next output follows 4 further accepted bits.
6. CHANNELS=2, DEPTH=4, mask=4'b1111, mode=0: feed ch0=1,1,1,1 and ch1=1,0,0,0 → first out_bit=2'b10 (ch1=1, ch0=0); a single shared out_valid pulse.

Source files
------------

// File: rtl/tt_xor_extractor.sv
// Per-channel DEPTH-bit shift window; emits parity of masked taps, sliding or block-decimated.
// Result registered on the accepting edge (1-cycle latency); no backpressure, in_valid gates shifting.
module tt_xor_extractor #(
  parameter int DEPTH    = 13,
  parameter int CHANNELS = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  input  logic [CHANNELS-1:0] num,
  input  logic [DEPTH-1:0]    tap_mask,
  input  logic                mode,
  output logic                out_valid,
  output logic [CHANNELS-1:0] out_bit,
  output logic                primed
);

  localparam int FW = $clog2(DEPTH + 1);
  localparam int BW = $clog2(DEPTH);
  localparam logic [FW-1:0] FILL_MAX = FW'(DEPTH);
  localparam logic [BW-1:0] BLK_LAST = BW'(DEPTH - 1);

  logic [DEPTH-1:0]    w_q [CHANNELS];
  logic [DEPTH-1:0]    w_d [CHANNELS];
  logic [DEPTH-1:0]    nw  [CHANNELS];
  logic [FW-1:0]       fill_q, fill_d;
  logic [BW-1:0]       blk_q, blk_d;
  logic                mode_q, mode_d;
  logic                vld_q, vld_d;
  logic [CHANNELS-1:0] bit_q, bit_d, par;
  logic                mode_chg, accept, emit;

  always_comb begin
    mode_chg = (mode != mode_q);
    // A mode change drops the cycle's input so both modes restart from an empty count.
    accept   = in_valid && !mode_chg;
    par      = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      nw[c]  = {w_q[c][DEPTH-2:0], num[c]};
      par[c] = ^(nw[c] & tap_mask);
      w_d[c] = w_q[c];
    end
    emit   = accept && (mode_q ? (blk_q == BLK_LAST) : (fill_q >= FILL_MAX - 1'b1));
    fill_d = fill_q;
    blk_d  = blk_q;
    mode_d = mode;
    vld_d  = emit;
    bit_d  = emit ? par : bit_q;
    if (mode_chg) begin
      fill_d = '0;
      blk_d  = '0;
    end else if (accept) begin
      for (int c = 0; c < CHANNELS; c++) begin
        w_d[c] = nw[c];
      end
      if (fill_q != FILL_MAX) begin
        fill_d = fill_q + 1'b1;
      end
      if (mode_q) begin
        blk_d = (blk_q == BLK_LAST) ? '0 : blk_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      for (int c = 0; c < CHANNELS; c++) begin
        w_q[c] <= '0;
      end
      fill_q <= '0;
      blk_q  <= '0;
      mode_q <= mode;
      vld_q  <= 1'b0;
      bit_q  <= '0;
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        w_q[c] <= w_d[c];
      end
      fill_q <= fill_d;
      blk_q  <= blk_d;
      mode_q <= mode_d;
      vld_q  <= vld_d;
      bit_q  <= bit_d;
    end
  end

  assign out_valid = vld_q;
  assign out_bit   = bit_q;
  assign primed    = (fill_q == FILL_MAX);

endmodule

// File: tb/tb_tt_xor_extractor.sv
// Bench for tt_xor_extractor at DEPTH=4, CHANNELS=2: directed scenarios plus a random run
// against a history-queue reference model.
module tb_tt_xor_extractor;

  logic       clk = 1'b0;
  logic       rst_n, in_valid, mode;
  logic [1:0] num;
  logic [3:0] tap_mask;
  logic       out_valid, primed;
  logic [1:0] out_bit;

  int n_chk = 0;
  int n_fail = 0;

  // reference model: everything accepted since the last clear, newest at the back
  int         cnt;
  logic [1:0] hist[$];
  logic       m_mode;
  logic       exp_vld, exp_primed;
  logic [1:0] exp_bit;

  tt_xor_extractor #(.DEPTH(4), .CHANNELS(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .num(num), .tap_mask(tap_mask),
    .mode(mode), .out_valid(out_valid), .out_bit(out_bit), .primed(primed)
  );

  always #5 clk = ~clk;

  task automatic step(input logic v, input logic [1:0] n, input logic [3:0] mk,
                      input logic md, input logic r);
    rst_n = r; in_valid = v; num = n; tap_mask = mk; mode = md;
    @(posedge clk);
    if (r) begin
      cnt = 0; hist.delete(); m_mode = md; exp_vld = 0; exp_bit = 0;
    end else if (md != m_mode) begin
      m_mode = md; cnt = 0; hist.delete(); exp_vld = 0;
    end else if (v) begin
      hist.push_back(n);
      if (hist.size() > 8) void'(hist.pop_front());
      cnt++;
      exp_vld = m_mode ? (cnt % 4 == 0) : (cnt >= 4);
      if (exp_vld) begin
        exp_bit = 2'b00;
        for (int i = 0; i < 4; i++)
          if (mk[i]) exp_bit ^= hist[hist.size()-1-i];
      end
    end else begin
      exp_vld = 0;
    end
    exp_primed = (cnt >= 4);
    #1;
  endtask

  task automatic test_reset();
    step(0, 2'b11, 4'hF, 0, 1);
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_vld: got %b want 0", out_valid); end
    n_chk++; if (out_bit !== 2'b00) begin n_fail++; $display("FAIL reset_bit: got %b want 00", out_bit); end
    n_chk++; if (primed !== 1'b0) begin n_fail++; $display("FAIL reset_primed: got %b want 0", primed); end
  endtask

  task automatic test_sliding();
    bit s [4];
    s = '{1, 0, 1, 1};
    step(0, 0, 4'hF, 0, 1);
    for (int i = 0; i < 4; i++) begin
      step(1, {1'b0, s[i]}, 4'hF, 0, 0);
      n_chk++; if (out_valid !== (i == 3)) begin n_fail++; $display("FAIL slide_vld[%0d]: got %b want %b", i, out_valid, i == 3); end
    end
    n_chk++; if (out_bit[0] !== 1'b1) begin n_fail++; $display("FAIL slide_bit4: got %b want 1", out_bit[0]); end
    n_chk++; if (primed !== 1'b1) begin n_fail++; $display("FAIL slide_primed: got %b want 1", primed); end
    step(1, 2'b00, 4'hF, 0, 0);
    n_chk++; if (out_valid !== 1'b1 || out_bit[0] !== 1'b0) begin n_fail++; $display("FAIL slide_bit5: got vld=%b bit=%b want vld=1 bit=0", out_valid, out_bit[0]); end
  endtask

  task automatic test_mask();
    bit s [4];
    bit t [4];
    bit e [4];
    s = '{1, 0, 0, 1};
    t = '{0, 1, 1, 0};
    e = '{0, 0, 1, 0};
    for (int i = 0; i < 4; i++) begin
      step(1, {1'b0, s[i]}, 4'b0001, 0, 0);
      n_chk++; if (out_valid !== 1'b1 || out_bit[0] !== s[i]) begin n_fail++; $display("FAIL mask_newest[%0d]: got vld=%b bit=%b want vld=1 bit=%b", i, out_valid, out_bit[0], s[i]); end
    end
    for (int i = 0; i < 4; i++) begin
      step(1, {1'b0, t[i]}, 4'b1000, 0, 0);
      n_chk++; if (out_valid !== 1'b1 || out_bit[0] !== e[i]) begin n_fail++; $display("FAIL mask_oldest[%0d]: got vld=%b bit=%b want vld=1 bit=%b", i, out_valid, out_bit[0], e[i]); end
    end
  endtask

  task automatic test_block();
    bit s [8];
    s = '{1, 1, 0, 0, 1, 0, 0, 0};
    step(0, 0, 4'hF, 1, 1);
    for (int i = 0; i < 8; i++) begin
      step(1, {1'b0, s[i]}, 4'hF, 1, 0);
      n_chk++; if (out_valid !== (i == 3 || i == 7)) begin n_fail++; $display("FAIL block_vld[%0d]: got %b want %b", i, out_valid, (i == 3 || i == 7)); end
      if (i == 3) begin
        n_chk++; if (out_bit[0] !== 1'b0) begin n_fail++; $display("FAIL block_bit1: got %b want 0", out_bit[0]); end
      end
      if (i == 7) begin
        n_chk++; if (out_bit[0] !== 1'b1) begin n_fail++; $display("FAIL block_bit2: got %b want 1", out_bit[0]); end
      end
    end
  endtask

  task automatic test_stall();
    step(0, 0, 4'hF, 0, 1);
    step(1, 2'b01, 4'hF, 0, 0);
    step(1, 2'b00, 4'hF, 0, 0);
    for (int i = 0; i < 5; i++) begin
      step(0, 2'b11, 4'hF, 0, 0);
      n_chk++; if (out_valid !== 1'b0 || primed !== 1'b0) begin n_fail++; $display("FAIL stall_gap[%0d]: got vld=%b primed=%b want 0 0", i, out_valid, primed); end
    end
    step(1, 2'b01, 4'hF, 0, 0);
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stall_vld3: got %b want 0", out_valid); end
    step(1, 2'b01, 4'hF, 0, 0);
    n_chk++; if (out_valid !== 1'b1 || out_bit[0] !== 1'b1) begin n_fail++; $display("FAIL stall_out: got vld=%b bit=%b want 1 1", out_valid, out_bit[0]); end
  endtask

  task automatic test_reset_mid();
    bit s [4];
    s = '{1, 0, 0, 0};
    step(0, 0, 4'hF, 0, 1);
    step(1, 2'b11, 4'hF, 0, 0);
    step(1, 2'b11, 4'hF, 0, 0);
    step(1, 2'b11, 4'hF, 0, 1);
    n_chk++; if (primed !== 1'b0 || out_bit !== 2'b00 || out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_state: got primed=%b bit=%b vld=%b want 0 00 0", primed, out_bit, out_valid); end
    for (int i = 0; i < 4; i++) begin
      step(1, {1'b0, s[i]}, 4'hF, 0, 0);
      n_chk++; if (out_valid !== (i == 3)) begin n_fail++; $display("FAIL midrst_vld[%0d]: got %b want %b", i, out_valid, i == 3); end
    end
    n_chk++; if (out_bit[0] !== 1'b1) begin n_fail++; $display("FAIL midrst_bit: got %b want 1", out_bit[0]); end
  endtask

  task automatic test_mode_change();
    bit s [4];
    s = '{1, 0, 0, 0};
    step(0, 0, 4'hF, 0, 1);
    for (int i = 0; i < 4; i++) step(1, 2'b01, 4'hF, 0, 0);
    step(1, 2'b01, 4'hF, 1, 0);
    n_chk++; if (out_valid !== 1'b0 || primed !== 1'b0) begin n_fail++; $display("FAIL modechg_state: got vld=%b primed=%b want 0 0", out_valid, primed); end
    for (int i = 0; i < 4; i++) begin
      step(1, {1'b0, s[i]}, 4'hF, 1, 0);
      n_chk++; if (out_valid !== (i == 3)) begin n_fail++; $display("FAIL modechg_vld[%0d]: got %b want %b", i, out_valid, i == 3); end
    end
    n_chk++; if (out_bit[0] !== 1'b1 || primed !== 1'b1) begin n_fail++; $display("FAIL modechg_out: got bit=%b primed=%b want 1 1", out_bit[0], primed); end
  endtask

  task automatic test_two_channel();
    bit c1 [4];
    c1 = '{1, 0, 0, 0};
    step(0, 0, 4'hF, 0, 1);
    for (int i = 0; i < 4; i++) begin
      step(1, {c1[i], 1'b1}, 4'hF, 0, 0);
      n_chk++; if (out_valid !== (i == 3)) begin n_fail++; $display("FAIL twoch_vld[%0d]: got %b want %b", i, out_valid, i == 3); end
    end
    n_chk++; if (out_bit !== 2'b10) begin n_fail++; $display("FAIL twoch_bit: got %b want 10", out_bit); end
  endtask

  task automatic test_random();
    logic md;
    md = 1'b0;
    step(0, 0, 4'hF, md, 1);
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(99) < 4) md = ~md;
      step(($urandom_range(99) < 70), 2'($urandom), 4'($urandom), md, ($urandom_range(99) < 2));
      n_chk++; if (out_valid !== exp_vld) begin n_fail++; $display("FAIL rand_vld[%0d]: got %b want %b", i, out_valid, exp_vld); end
      n_chk++; if (primed !== exp_primed) begin n_fail++; $display("FAIL rand_primed[%0d]: got %b want %b", i, primed, exp_primed); end
      if (exp_vld) begin
        n_chk++; if (out_bit !== exp_bit) begin n_fail++; $display("FAIL rand_bit[%0d]: got %b want %b", i, out_bit, exp_bit); end
      end
    end
  endtask

  initial begin
    rst_n = 1'b1; in_valid = 1'b0; num = '0; tap_mask = '0; mode = 1'b0;
    cnt = 0; m_mode = 1'b0; exp_vld = 0; exp_bit = 0; exp_primed = 0;
    test_reset();
    test_sliding();
    test_mask();
    test_block();
    test_stall();
    test_reset_mid();
    test_mode_change();
    test_two_channel();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
